// File: rtl/matmul_pkg.sv
`default_nettype none
// =============================================================================
// matmul_pkg - shared state encoding, sizing helper and default widths (rev 1.0)
// =============================================================================
package matmul_pkg;

  localparam int DW_DEFAULT   = 8;
  localparam int ACCW_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Address/counter width for n entries, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// =============================================================================
// matmul_mac - signed multiply-accumulate behind a 1-cycle operand read (rev 1.0)
// =============================================================================
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int ACCW = ACCW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   clr,
  input  logic signed [DW-1:0]   a_data,
  input  logic signed [DW-1:0]   b_data,
  output logic signed [ACCW-1:0] acc
);

  logic                   rd_valid_d1;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;

  assign prod     = (2*DW)'(a_data) * (2*DW)'(b_data);
  // Sign-extends when ACCW is wider than the product, truncates (wraps) otherwise.
  assign prod_ext = ACCW'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_d1 <= 1'b0;
      acc         <= '0;
    end else begin
      rd_valid_d1 <= rd_en;
      if (clr)
        acc <= '0;
      else if (rd_valid_d1)
        acc <= acc + prod_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// =============================================================================
// matmul_seq_ctrl - restartable i/j/k schedule for one shared MAC (rev 1.0)
// =============================================================================
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter  int A_ROWS = 2,
  parameter  int A_COLS = 2,
  parameter  int B_COLS = 2,
  parameter  int DW     = DW_DEFAULT,
  parameter  int ACCW   = ACCW_DEFAULT,
  localparam int AW_A   = clog2(A_ROWS * A_COLS),
  localparam int AW_B   = clog2(A_COLS * B_COLS),
  localparam int AW_R   = clog2(A_ROWS * B_COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW_A-1:0] a_addr,
  output logic [AW_B-1:0] b_addr,
  input  logic [DW-1:0]   a_data,
  input  logic [DW-1:0]   b_data,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [AW_R-1:0] r_addr,
  output logic [ACCW-1:0] r_data
);

  localparam int IW = clog2(A_ROWS);
  localparam int JW = clog2(B_COLS);
  localparam int KW = clog2(A_COLS);

  state_t                 state;
  logic [IW-1:0]          i, i_nx;
  logic [JW-1:0]          j, j_nx;
  logic [KW-1:0]          k, k_nx;
  logic                   i_last, j_last, k_last, last_elem;
  logic                   clr;
  logic signed [ACCW-1:0] acc;

  function automatic logic [AW_A-1:0] a_idx(input logic [IW-1:0] ii, input logic [KW-1:0] kk);
    return AW_A'(int'(ii) * A_COLS + int'(kk));
  endfunction

  function automatic logic [AW_B-1:0] b_idx(input logic [KW-1:0] kk, input logic [JW-1:0] jj);
    return AW_B'(int'(kk) * B_COLS + int'(jj));
  endfunction

  function automatic logic [AW_R-1:0] r_idx(input logic [IW-1:0] ii, input logic [JW-1:0] jj);
    return AW_R'(int'(ii) * B_COLS + int'(jj));
  endfunction

  assign k_last    = (k == KW'(A_COLS - 1));
  assign j_last    = (j == JW'(B_COLS - 1));
  assign i_last    = (i == IW'(A_ROWS - 1));
  assign last_elem = i_last && j_last;
  assign k_nx      = k + KW'(1);
  assign j_nx      = j_last ? '0 : j + JW'(1);
  assign i_nx      = j_last ? i + IW'(1) : i;

  // Clearing only on ISSUE entry is safe: the DRAIN cycle has already absorbed the last product.
  assign clr    = ((state == IDLE) && start) ||
                  ((state == WRITE) && r_ready && !last_elem);
  assign r_data = acc;

  matmul_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rd_en),
    .clr    (clr),
    .a_data (a_data),
    .b_data (b_data),
    .acc    (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      r_valid <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      r_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ISSUE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            busy   <= 1'b1;
            rd_en  <= 1'b1;
            a_addr <= '0;
            b_addr <= '0;
          end
        end
        ISSUE: begin
          if (k_last) begin
            state <= DRAIN;
            k     <= '0;
            rd_en <= 1'b0;
          end else begin
            k      <= k_nx;
            a_addr <= a_idx(i, k_nx);
            b_addr <= b_idx(k_nx, j);
          end
        end
        DRAIN: begin
          state   <= WRITE;
          r_valid <= 1'b1;
          r_addr  <= r_idx(i, j);
        end
        WRITE: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            if (last_elem) begin
              state <= DONE;
              done  <= 1'b1;
              i     <= '0;
              j     <= '0;
            end else begin
              state  <= ISSUE;
              i      <= i_nx;
              j      <= j_nx;
              rd_en  <= 1'b1;
              a_addr <= a_idx(i_nx, '0);
              b_addr <= b_idx('0, j_nx);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
// =============================================================================
// tb_matmul_seq_ctrl - scoreboard bench over three shape configurations (rev 1.0)
// =============================================================================
module tb_matmul_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       r_ready;
  logic [2:0] start_v;

  // u_sq: 2x2x2, ACCW=16
  logic       busy0, done0, rd_en0, r_valid0;
  logic [1:0] a_addr0, b_addr0, r_addr0;
  logic [7:0] a_data0, b_data0;
  logic [15:0] r_data0;
  // u_wrap: 1x2x1, ACCW=8
  logic       busy1, done1, rd_en1, r_valid1;
  logic [0:0] a_addr1, b_addr1, r_addr1;
  logic [7:0] a_data1, b_data1;
  logic [7:0] r_data1;
  // u_ns: 2x3x1, ACCW=16
  logic       busy2, done2, rd_en2, r_valid2;
  logic [2:0] a_addr2;
  logic [1:0] b_addr2;
  logic [0:0] r_addr2;
  logic [7:0] a_data2, b_data2;
  logic [15:0] r_data2;

  matmul_seq_ctrl u_sq (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy0), .done(done0),
    .rd_en(rd_en0), .a_addr(a_addr0), .b_addr(b_addr0), .a_data(a_data0), .b_data(b_data0),
    .r_valid(r_valid0), .r_ready(r_ready), .r_addr(r_addr0), .r_data(r_data0));

  matmul_seq_ctrl #(.A_ROWS(1), .A_COLS(2), .B_COLS(1), .DW(8), .ACCW(8)) u_wrap (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .a_addr(a_addr1), .b_addr(b_addr1), .a_data(a_data1), .b_data(b_data1),
    .r_valid(r_valid1), .r_ready(r_ready), .r_addr(r_addr1), .r_data(r_data1));

  matmul_seq_ctrl #(.A_ROWS(2), .A_COLS(3), .B_COLS(1), .DW(8), .ACCW(16)) u_ns (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .a_addr(a_addr2), .b_addr(b_addr2), .a_data(a_data2), .b_data(b_data2),
    .r_valid(r_valid2), .r_ready(r_ready), .r_addr(r_addr2), .r_data(r_data2));

  // Operand memories with one cycle of read latency.
  logic [7:0] ma0 [4];
  logic [7:0] mb0 [4];
  logic [7:0] ma1 [2];
  logic [7:0] mb1 [2];
  logic [7:0] ma2 [6];
  logic [7:0] mb2 [3];

  always @(posedge clk) begin
    if (rd_en0) begin a_data0 <= ma0[a_addr0]; b_data0 <= mb0[b_addr0]; end
    if (rd_en1) begin a_data1 <= ma1[a_addr1]; b_data1 <= mb1[b_addr1]; end
    if (rd_en2) begin a_data2 <= ma2[a_addr2]; b_data2 <= mb2[b_addr2]; end
  end

  logic [2:0]  rv, busy_v, done_v, rd_v;
  logic [15:0] ra  [3];
  logic [15:0] rdv [3];
  logic [63:0] outs [3];

  assign rv     = {r_valid2, r_valid1, r_valid0};
  assign busy_v = {busy2, busy1, busy0};
  assign done_v = {done2, done1, done0};
  assign rd_v   = {rd_en2, rd_en1, rd_en0};
  assign ra[0]  = 16'(r_addr0);
  assign ra[1]  = 16'(r_addr1);
  assign ra[2]  = 16'(r_addr2);
  assign rdv[0] = r_data0;
  assign rdv[1] = 16'(r_data1);
  assign rdv[2] = r_data2;
  assign outs[0] = 64'({busy0, done0, rd_en0, r_valid0, a_addr0, b_addr0, r_addr0, r_data0});
  assign outs[1] = 64'({busy1, done1, rd_en1, r_valid1, a_addr1, b_addr1, r_addr1, r_data1});
  assign outs[2] = 64'({busy2, done2, rd_en2, r_valid2, a_addr2, b_addr2, r_addr2, r_data2});

  typedef struct {
    int          dut;
    int          addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int d, input int a, input logic [15:0] v);
    exp_t e;
    e.dut  = d;
    e.addr = a;
    e.data = v;
    exp_q.push_back(e);
  endtask

  // Downstream: optionally withholds r_ready for 3 cycles of every u_sq result.
  bit bp_mode  = 1'b0;
  int hold_cnt = 0;
  initial begin
    r_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_mode && r_valid0 && hold_cnt < 3) begin
        r_ready = 1'b0;
        hold_cnt++;
      end else begin
        r_ready  = 1'b1;
        hold_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted result, checks stability while stalled.
  logic [2:0]  pend;
  logic [15:0] hold_a [3];
  logic [15:0] hold_d [3];
  initial begin
    exp_t e;
    pend = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (rst || !rv[d]) begin
          pend[d] = 1'b0;
        end else begin
          if (pend[d]) begin
            chk("stall_addr_stable", 64'(ra[d]), 64'(hold_a[d]));
            chk("stall_data_stable", 64'(rdv[d]), 64'(hold_d[d]));
          end
          if (r_ready) begin
            pend[d] = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_result", 64'(exp_q.size()), 64'd1);
            end else begin
              e = exp_q.pop_front();
              chk("result_dut", 64'(d), 64'(e.dut));
              chk("result_addr", 64'(ra[d]), 64'(e.addr));
              chk("result_data", 64'(rdv[d]), 64'(e.data));
            end
          end else begin
            pend[d]   = 1'b1;
            hold_a[d] = ra[d];
            hold_d[d] = rdv[d];
          end
        end
      end
    end
  end

  // One run on DUT d; cycle n counts edges after the start-accepting edge.
  task automatic run(input int d, input int exp_done, input int exp_rd,
                     input int repulse_at, input int abort_at);
    int cyc;
    int rd_cnt;
    int dcnt;
    bit seen;
    cyc    = -1;
    rd_cnt = 0;
    dcnt   = 0;
    seen   = 1'b0;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (abort_at > 0 && n == abort_at + 1) begin
        chk("abort_outputs_zero", outs[d], 64'd0);
        rst = 1'b0;
        break;
      end
      rd_cnt += int'(rd_v[d]);
      if (n == repulse_at) start_v[d] = 1'b1;
      if (n == repulse_at + 1) start_v[d] = 1'b0;
      if (abort_at > 0 && n == abort_at) rst = 1'b1;
      if (done_v[d]) begin
        seen = 1'b1;
        cyc  = n;
        break;
      end
    end
    chk("rd_en_cycles", 64'(rd_cnt), 64'(exp_rd));
    if (abort_at > 0) begin
      repeat (20) begin
        @(negedge clk);
        dcnt += int'(done_v[d]);
      end
      chk("no_done_after_abort", 64'(dcnt + int'(seen)), 64'd0);
    end else begin
      chk("done_cycle", 64'(cyc), 64'(exp_done));
      chk("busy_during_done", 64'(busy_v[d]), 64'd1);
      @(negedge clk);
      chk("done_pulse_width", 64'(done_v[d]), 64'd0);
      chk("busy_low_after", 64'(busy_v[d]), 64'd0);
    end
    chk("results_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start_v = '0;
    ma0 = '{8'd1, 8'd0, 8'd0, 8'd1};
    mb0 = '{8'd1, 8'd2, 8'd3, 8'd4};
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("reset_outputs_zero", outs[d], 64'd0);
    rst = 1'b0;

    // Identity times B
    push(0, 0, 16'd1); push(0, 1, 16'd2); push(0, 2, 16'd3); push(0, 3, 16'd4);
    run(0, 17, 8, 0, 0);

    // Signed operands
    ma0 = '{8'hFF, 8'd2, 8'd3, 8'hFC};
    mb0 = '{8'd5, 8'd6, 8'd7, 8'd8};
    push(0, 0, 16'h0009); push(0, 1, 16'h000A); push(0, 2, 16'hFFF3); push(0, 3, 16'hFFF2);
    run(0, 17, 8, 0, 0);

    // Backpressure: 3 stalled cycles per result
    bp_mode = 1'b1;
    push(0, 0, 16'h0009); push(0, 1, 16'h000A); push(0, 2, 16'hFFF3); push(0, 3, 16'hFFF2);
    run(0, 29, 8, 0, 0);
    bp_mode = 1'b0;

    // start re-pulsed mid-run is ignored
    push(0, 0, 16'h0009); push(0, 1, 16'h000A); push(0, 2, 16'hFFF3); push(0, 3, 16'hFFF2);
    run(0, 17, 8, 5, 0);

    // Reset during the second element: only the first result escapes
    push(0, 0, 16'h0009);
    run(0, 0, 4, 0, 7);

    // Clean run after the abort
    push(0, 0, 16'h0009); push(0, 1, 16'h000A); push(0, 2, 16'hFFF3); push(0, 3, 16'hFFF2);
    run(0, 17, 8, 0, 0);

    // 8-bit accumulator wraps: 2 * 16129 mod 256 = 2
    ma1 = '{8'd127, 8'd127};
    mb1 = '{8'd127, 8'd127};
    push(1, 0, 16'h0002);
    run(1, 5, 2, 0, 0);

    // Non-square 2x3 times 3x1
    ma2 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    mb2 = '{8'd1, 8'd1, 8'd1};
    push(2, 0, 16'd6); push(2, 1, 16'd15);
    run(2, 11, 6, 0, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
